// File: rtl/mips32_pkg.sv
// mips32_pkg: shared fetch-queue FSM encoding and NOP constant
package mips32_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN} fq_state_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear, full/empty flags
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer with single outstanding memory request
module fetch_queue
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        o_valid,
    output logic [31:0] oIR,
    output logic [31:0] oPC
);
    fq_state_t   state;
    logic [31:0] fetch_pc;
    logic [63:0] head;
    logic        push, pop, full, empty;
    assign push = state == WAIT_ACK && imem_ack && !flush;
    assign pop  = o_valid && !hold && !flush;
    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .clear(flush), .push(push), .pop(pop),
        .wdata({fetch_pc + 32'd4, imem_rdata}), .rdata(head), .full(full), .empty(empty)
    );
    assign o_valid = !empty;
    assign oIR     = o_valid ? head[31:0] : NOP;
    assign oPC     = o_valid ? head[63:32] : NOP;
    // imem_addr latches the request address so DRAIN can keep presenting it after a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            if (flush) fetch_pc <= redirect_pc;
            else if (push) fetch_pc <= fetch_pc + 32'd4;
            case (state)
                IDLE: if (!flush && !full) begin
                    state     <= WAIT_ACK;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                WAIT_ACK: if (imem_ack) begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end else if (flush) state <= DRAIN;
                DRAIN: if (imem_ack) begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic        clk = 0, reset = 1;
    logic        imem_req, imem_ack = 0, hold = 0, flush = 0, o_valid;
    logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, oIR, oPC;
    int n_checks = 0, n_fail = 0;

    fetch_queue dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .hold(hold), .flush(flush),
        .redirect_pc(redirect_pc), .o_valid(o_valid), .oIR(oIR), .oPC(oPC)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1; flush = 0; imem_ack = 0;
        tick; tick;
        reset = 0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick;
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic ack(input logic [31:0] d);
        imem_ack = 1; imem_rdata = d;
        tick;
        imem_ack = 0;
    endtask

    initial begin
        int reqs;
        tick; tick;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ir", oIR, 32'h0);
        chk("rst_pc", oPC, 32'h0);
        reset = 0;

        // sequential fetch, each entry consumed the cycle after it lands
        for (int i = 0; i < 4; i++) begin
            wait_req("seq", 32'(i * 4));
            ack(32'h2001_0005 + 32'(i));
            chk("seq_valid", 32'(o_valid), 32'd1);
            chk("seq_ir", oIR, 32'h2001_0005 + 32'(i));
            chk("seq_pc", oPC, 32'(i * 4 + 4));
        end
        tick;
        chk("seq_drained", 32'(o_valid), 32'd0);

        // hold: fill to DEPTH then stop requesting
        do_reset;
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            wait_req("fill", 32'(i * 4));
            ack(32'h1000 + 32'(i));
        end
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) reqs++;
            tick;
        end
        chk("full_noreq", 32'(reqs), 32'd0);
        chk("full_head_ir", oIR, 32'h1000);
        chk("full_head_pc", oPC, 32'h4);
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            chk("pop_ir", oIR, 32'h1000 + 32'(i));
            tick;
        end
        chk("pop_empty", 32'(o_valid), 32'd0);
        chk("pop_nop", oIR, 32'h0);

        // reset during WAIT_ACK with a late ack
        wait_req("rstmid", 32'h10);
        reset = 1; imem_ack = 1; imem_rdata = 32'hCAFE_0001;
        tick;
        reset = 0;
        tick;
        imem_ack = 0;
        chk("rstmid_nopush", 32'(o_valid), 32'd0);
        wait_req("rstmid_next", 32'h0);

        // flush with 3 buffered entries
        do_reset;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            wait_req("f3", 32'(i * 4));
            ack(32'h3000 + 32'(i));
        end
        chk("f3_valid", 32'(o_valid), 32'd1);
        flush = 1; redirect_pc = 32'h100;
        tick;
        flush = 0;
        chk("f3_flushed", 32'(o_valid), 32'd0);
        wait_req("f3_redir", 32'h100);
        ack(32'hAAAA_0000);
        chk("f3_ir", oIR, 32'hAAAA_0000);
        chk("f3_pc", oPC, 32'h104);

        // flush during WAIT_ACK -> DRAIN, refreshed redirect, late ack discarded
        do_reset;
        hold = 1;
        wait_req("d0", 32'h0); ack(32'h4000);
        wait_req("d1", 32'h4); ack(32'h4001);
        wait_req("d2", 32'h8);
        flush = 1; redirect_pc = 32'h180;
        tick;
        redirect_pc = 32'h200;
        tick;
        flush = 0;
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr", imem_addr, 32'h8);
        chk("drain_valid", 32'(o_valid), 32'd0);
        tick;
        ack(32'hDEAD_BEEF);
        chk("drain_discard", 32'(o_valid), 32'd0);
        wait_req("drain_redir", 32'h200);
        chk("drain_novalid", 32'(o_valid), 32'd0);
        ack(32'h1111_1111);
        chk("drain_ir", oIR, 32'h1111_1111);
        chk("drain_pc", oPC, 32'h204);

        // address wrap, then flush coincident with ack
        do_reset;
        hold = 1;
        flush = 1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        flush = 0;
        wait_req("wrap", 32'hFFFF_FFFC);
        ack(32'h1234_5678);
        chk("wrap_ir", oIR, 32'h1234_5678);
        chk("wrap_pc", oPC, 32'h0);
        wait_req("wrap_next", 32'h0);
        flush = 1; redirect_pc = 32'h300;
        ack(32'h0000_0BAD);
        flush = 0;
        chk("coinc_valid", 32'(o_valid), 32'd0);
        chk("coinc_req", 32'(imem_req), 32'd0);
        wait_req("coinc_redir", 32'h300);
        ack(32'h5555_5555);
        chk("coinc_ir", oIR, 32'h5555_5555);
        chk("coinc_pc", oPC, 32'h304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
